// File: rtl/regwb_pkg.sv
// Shared constants and the queued-write entry type for the register-file writeback controller.
package regwb_pkg;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam logic [AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic          live;
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } entry_t;

endpackage

// File: rtl/regwb_fifo.sv
// Secondary writeback FIFO: entry storage, wrap-around pointers, kill-by-register and
// parallel per-operand live-match lookup (youngest live match wins the data output).
module regwb_fifo
   import regwb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NCHK  = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  entry_t                         push_entry,
   input  logic                           pop,
   input  logic                           kill,
   input  logic [AW-1:0]                  kill_reg,
   input  logic [NCHK-1:0][AW-1:0]        chk_reg,
   output entry_t                         head,
   output logic [CW-1:0]                  count,
   output logic [NCHK-1:0]                match,
   output logic [NCHK-1:0][DW-1:0]        match_data
);

   entry_t          mem [DEPTH];
   logic [PW-1:0]   head_ptr;
   logic [PW-1:0]   tail_ptr;

   assign head = mem[head_ptr];

   // Live bits are cleared on pop, so live implies occupied for the match logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i].live <= 1'b0;
      end else begin
         if (kill) begin
            for (int i = 0; i < DEPTH; i++)
               if (mem[i].rd == kill_reg)
                  mem[i].live <= 1'b0;
         end
         if (pop) begin
            mem[head_ptr].live <= 1'b0;
            head_ptr           <= head_ptr + PW'(1);
         end
         if (push) begin
            mem[tail_ptr] <= push_entry;
            tail_ptr      <= tail_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Scan oldest to youngest so the last hit is the entry nearest the tail.
   for (genvar c = 0; c < NCHK; c++) begin : g_chk
      logic [PW-1:0] slot;
      always_comb begin
         match[c]      = 1'b0;
         match_data[c] = '0;
         slot          = '0;
         for (int k = 0; k < DEPTH; k++) begin
            slot = head_ptr + PW'(k);
            if (mem[slot].live && mem[slot].rd == chk_reg[c]) begin
               match[c]      = 1'b1;
               match_data[c] = mem[slot].data;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: primary writeback beats the queued secondary source.
// Optional REGWB_FWD_EN adds forwarding outputs that replace the hazard stall.
module regfile_wb_ctrl
   import regwb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = regwb_pkg::AW,
   parameter int DW    = regwb_pkg::DW,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pri_we,
   input  logic [AW-1:0] pri_reg,
   input  logic [DW-1:0] pri_data,
   input  logic          sec_valid,
   output logic          sec_ready,
   input  logic [AW-1:0] sec_reg,
   input  logic [DW-1:0] sec_data,
   output logic          RegWrite,
   output logic [AW-1:0] wr_reg,
   output logic [DW-1:0] wr_data,
   input  logic [AW-1:0] chk_reg1,
   input  logic [AW-1:0] chk_reg2,
   output logic          hazard1,
   output logic          hazard2,
`ifdef REGWB_FWD_EN
   output logic          fwd_hit1,
   output logic          fwd_hit2,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2,
`endif
   output logic [CW-1:0] count
);

   logic                 pri_act;
   logic                 push;
   logic                 pop;
   entry_t               push_entry;
   entry_t               head;
   logic [1:0]           match;
   logic [1:0][DW-1:0]   match_data;

   assign pri_act   = pri_we && (pri_reg != REG_ZERO);
   assign sec_ready = count < CW'(DEPTH);
   assign push      = sec_valid && sec_ready && (sec_reg != REG_ZERO);
   assign pop       = !pri_act && (count != '0);

   // A same-cycle primary write to the same register makes the queued copy stale.
   always_comb begin
      push_entry      = '0;
      push_entry.live = !(pri_act && sec_reg == pri_reg);
      push_entry.rd   = sec_reg;
      push_entry.data = sec_data;
   end

   regwb_fifo #(.DEPTH(DEPTH), .NCHK(2)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill       (pri_act),
      .kill_reg   (pri_reg),
      .chk_reg    ({chk_reg2, chk_reg1}),
      .head       (head),
      .count      (count),
      .match      (match),
      .match_data (match_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite <= 1'b0;
         wr_reg   <= '0;
         wr_data  <= '0;
      end else if (pri_act) begin
         RegWrite <= 1'b1;
         wr_reg   <= pri_reg;
         wr_data  <= pri_data;
      end else if (pop) begin
         RegWrite <= head.live;
         if (head.live) begin
            wr_reg  <= head.rd;
            wr_data <= head.data;
         end
      end else begin
         RegWrite <= 1'b0;
      end
   end

`ifdef REGWB_FWD_EN
   assign fwd_hit1  = match[0] && (chk_reg1 != REG_ZERO);
   assign fwd_hit2  = match[1] && (chk_reg2 != REG_ZERO);
   assign fwd_data1 = match_data[0];
   assign fwd_data2 = match_data[1];
   assign hazard1   = match[0] && (chk_reg1 != REG_ZERO) && !fwd_hit1;
   assign hazard2   = match[1] && (chk_reg2 != REG_ZERO) && !fwd_hit2;
`else
   assign hazard1   = match[0] && (chk_reg1 != REG_ZERO);
   assign hazard2   = match[1] && (chk_reg2 != REG_ZERO);
   logic unused_data;
   assign unused_data = ^match_data;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: primary priority, FIFO fill/drain, kills, hazards, wrap, reset.
module tb_regfile_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        pri_we;
   logic [4:0]  pri_reg;
   logic [31:0] pri_data;
   logic        sec_valid;
   logic        sec_ready;
   logic [4:0]  sec_reg;
   logic [31:0] sec_data;
   logic        RegWrite;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [4:0]  chk_reg1;
   logic [4:0]  chk_reg2;
   logic        hazard1;
   logic        hazard2;
   logic [2:0]  count;
`ifdef REGWB_FWD_EN
   logic        fwd_hit1, fwd_hit2;
   logic [31:0] fwd_data1, fwd_data2;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   regfile_wb_ctrl #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .pri_we(pri_we), .pri_reg(pri_reg), .pri_data(pri_data),
      .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_reg(sec_reg), .sec_data(sec_data),
      .RegWrite(RegWrite), .wr_reg(wr_reg), .wr_data(wr_data),
      .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard1(hazard1), .hazard2(hazard2),
`ifdef REGWB_FWD_EN
      .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
      .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pri_we    = 1'b0;
      sec_valid = 1'b0;
   endtask

   // Push one secondary entry while a primary write to r31 blocks the pop path.
   task automatic push_blk(input logic [4:0] r, input logic [31:0] d);
      pri_we = 1'b1; pri_reg = 5'd31; pri_data = 32'h31;
      sec_valid = 1'b1; sec_reg = r; sec_data = d;
      step();
   endtask

   initial begin
      rst = 1'b1; idle();
      pri_reg = '0; pri_data = '0; sec_reg = '0; sec_data = '0;
      chk_reg1 = '0; chk_reg2 = '0;
      step(); step();
      rst = 1'b0;
      #1;
      check("rst_regwrite", 32'(RegWrite), 32'd0);
      check("rst_wr_reg",   32'(wr_reg),   32'd0);
      check("rst_wr_data",  wr_data,       32'd0);
      check("rst_count",    32'(count),    32'd0);
      check("rst_ready",    32'(sec_ready), 32'd1);

      // Primary write, 1-cycle latency
      pri_we = 1'b1; pri_reg = 5'd5; pri_data = 32'hDEADBEEF;
      step(); idle();
      check("pri_regwrite", 32'(RegWrite), 32'd1);
      check("pri_wr_reg",   32'(wr_reg),   32'd5);
      check("pri_wr_data",  wr_data,       32'hDEADBEEF);
      step();
      check("idle_regwrite", 32'(RegWrite), 32'd0);
      check("idle_hold_reg", 32'(wr_reg),   32'd5);

      // Fill 1..4, then drain; a primary write to r0 must not block the pop
      for (int r = 1; r <= 4; r++) push_blk(5'(r), 32'h100 + 32'(r));
      idle();
      pri_we = 1'b1; pri_reg = 5'd0; pri_data = 32'hBAD;
      chk_reg1 = 5'd3; chk_reg2 = 5'd0;
      #1;
      check("full_count",   32'(count),     32'd4);
      check("full_ready",   32'(sec_ready), 32'd0);
      check("full_haz1",    32'(hazard1),   32'd1);
      check("full_haz2",    32'(hazard2),   32'd0);
      check("full_pri31",   32'(wr_reg),    32'd31);
      step();
      check("drain1_reg",   32'(wr_reg),    32'd1);
      check("drain1_data",  wr_data,        32'h101);
      check("drain1_we",    32'(RegWrite),  32'd1);
      check("drain1_count", 32'(count),     32'd3);
      idle();
      step();
      check("drain2_reg",   32'(wr_reg),    32'd2);
      check("drain2_count", 32'(count),     32'd2);
      step();
      check("drain3_reg",   32'(wr_reg),    32'd3);
      check("drain3_haz1",  32'(hazard1),   32'd0);
      step();
      check("drain4_reg",   32'(wr_reg),    32'd4);
      check("drain4_data",  wr_data,        32'h104);
      check("drain4_count", 32'(count),     32'd0);
      step();
      check("empty_we",     32'(RegWrite),  32'd0);

      // Queued r7 killed by a later primary write to r7
      sec_valid = 1'b1; sec_reg = 5'd7; sec_data = 32'h11;
      step(); idle();
      chk_reg1 = 5'd7;
      #1;
      check("q7_count", 32'(count),   32'd1);
      check("q7_haz1",  32'(hazard1), 32'd1);
      pri_we = 1'b1; pri_reg = 5'd7; pri_data = 32'h22;
      step(); idle();
      check("k7_we",    32'(RegWrite), 32'd1);
      check("k7_reg",   32'(wr_reg),   32'd7);
      check("k7_data",  wr_data,       32'h22);
      check("k7_count", 32'(count),    32'd1);
      check("k7_haz1",  32'(hazard1),  32'd0);
      step();
      check("k7pop_we",    32'(RegWrite), 32'd0);
      check("k7pop_count", 32'(count),    32'd0);
      check("k7pop_data",  wr_data,       32'h22);

      // Same-cycle push and primary write to r8: enqueued dead
      sec_valid = 1'b1; sec_reg = 5'd8; sec_data = 32'h88;
      pri_we = 1'b1; pri_reg = 5'd8; pri_data = 32'h80;
      step(); idle();
      chk_reg1 = 5'd8;
      #1;
      check("s8_data",  wr_data,       32'h80);
      check("s8_count", 32'(count),    32'd1);
      check("s8_haz1",  32'(hazard1),  32'd0);
      step();
      check("s8pop_we",    32'(RegWrite), 32'd0);
      check("s8pop_count", 32'(count),    32'd0);

      // Push to r0 is accepted and discarded
      sec_valid = 1'b1; sec_reg = 5'd0; sec_data = 32'h55;
      #1;
      check("r0_ready", 32'(sec_ready), 32'd1);
      step(); idle();
      check("r0_count", 32'(count),    32'd0);
      check("r0_we",    32'(RegWrite), 32'd0);

      // Hazard on r9 until popped
      sec_valid = 1'b1; sec_reg = 5'd9; sec_data = 32'h99;
      step(); idle();
      chk_reg1 = 5'd9; chk_reg2 = 5'd0;
      #1;
      check("h9_haz1", 32'(hazard1), 32'd1);
      check("h9_haz2", 32'(hazard2), 32'd0);
      step();
      check("h9_reg",     32'(wr_reg),  32'd9);
      check("h9_data",    wr_data,      32'h99);
      check("h9_haz1clr", 32'(hazard1), 32'd0);

      // Full FIFO: pop only, then push+pop with wrap, then ordered drain
      for (int r = 11; r <= 14; r++) push_blk(5'(r), 32'h200 + 32'(r));
      idle();
      sec_valid = 1'b1; sec_reg = 5'd15; sec_data = 32'h215;
      #1;
      check("w_full_ready", 32'(sec_ready), 32'd0);
      step();
      check("w1_reg",   32'(wr_reg),    32'd11);
      check("w1_count", 32'(count),     32'd3);
      check("w1_ready", 32'(sec_ready), 32'd1);
      step(); idle();
      check("w2_reg",   32'(wr_reg),    32'd12);
      check("w2_count", 32'(count),     32'd3);
      step();
      check("w3_reg",   32'(wr_reg),    32'd13);
      step();
      check("w4_reg",   32'(wr_reg),    32'd14);
      step();
      check("w5_reg",   32'(wr_reg),    32'd15);
      check("w5_data",  wr_data,        32'h215);
      check("w5_count", 32'(count),     32'd0);

      // Reset with three queued writes
      for (int r = 21; r <= 23; r++) push_blk(5'(r), 32'h300 + 32'(r));
      idle();
      check("pre_rst_count", 32'(count), 32'd3);
      rst = 1'b1;
      step();
      chk_reg1 = 5'd21;
      #1;
      check("mrst_count", 32'(count),     32'd0);
      check("mrst_we",    32'(RegWrite),  32'd0);
      check("mrst_ready", 32'(sec_ready), 32'd1);
      check("mrst_haz1",  32'(hazard1),   32'd0);
      rst = 1'b0;
      step();
      check("post_rst_we", 32'(RegWrite), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
